// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lsu_bus_bridge : core load/store port to req/gnt/rvalid memory bus bridge
// Rev 1.0
// -----------------------------------------------------------------------------
module lsu_bus_bridge #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // Counter value at which a REQ/WAIT cycle without its exit event aborts.
  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        w_access;
  logic        w_misaligned;
  logic        w_expire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rshift;
  logic [31:0] w_rload;

  always_comb begin
    w_access     = MemRead | MemWrite;
    w_misaligned = ((Size == 2'd1) & Addr[0]) | (Size[1] & (Addr[1:0] != 2'd0));
    w_expire     = (cnt_q >= C_CNT_LAST);
    case (Size)
      2'd0: begin
        w_be    = 4'b0001 << Addr[1:0];
        w_wdata = {4{StoreData[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << Addr[1:0];
        w_wdata = {2{StoreData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = StoreData;
      end
    endcase
    // Right-align the addressed lane(s); sign extension happens downstream.
    w_rshift = bus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    w_rload = {24'd0, w_rshift[7:0]};
      2'd1:    w_rload = {16'd0, w_rshift[15:0]};
      default: w_rload = w_rshift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    off_d   = off_q;
    size_d  = size_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (w_access) begin
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          if (w_misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            we_d    = MemWrite;
            addr_d  = {Addr[31:2], 2'b00};
            be_d    = w_be;
            wdata_d = w_wdata;
            off_d   = Addr[1:0];
            size_d  = Size;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_gnt) begin
          state_d = S_WAIT;
        end else if (w_expire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_rvalid) begin
          if (!we_q) begin
            rdata_d = w_rload;
          end
          state_d = S_DONE;
        end else if (w_expire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      off_q   <= off_d;
      size_q  <= size_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign ReadData  = rdata_q;
  assign MemErr    = (state_q == S_DONE) & err_q;
  assign Stall     = (state_q != S_DONE) & ((state_q != S_IDLE) | w_access);

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
`default_nettype none
// Randomized + directed bench for lsu_bus_bridge against a transaction-level model.
module tb_lsu_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [1:0]  Size;
  logic [31:0] Addr, StoreData;
  logic [31:0] ReadData;
  logic        Stall, MemErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  lsu_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
    .Addr(Addr), .StoreData(StoreData), .ReadData(ReadData), .Stall(Stall), .MemErr(MemErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, tracked by what has happened to it.
  bit          m_busy, m_granted, m_finish, m_err, m_read, m_we, m_stall;
  int          m_used, m_off, m_n;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  logic        s_stall, s_req, s_err, s_we;
  logic [31:0] s_rd, s_addr, s_wdata;
  logic [3:0]  s_be;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_finish = 0; m_err = 0; m_read = 0; m_we = 0;
    m_used = 0; m_off = 0; m_n = 4;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0;
  endtask

  task automatic model_update();
    logic [31:0] r;
    if (m_finish) begin
      m_finish = 0;
    end else if (m_busy) begin
      if (!m_granted && bus_gnt) begin
        m_granted = 1;
      end else if (m_granted && bus_rvalid) begin
        m_busy = 0; m_finish = 1; m_err = 0;
        if (m_read) begin
          r = '0;
          for (int j = 0; j < m_n; j++) r[8*j +: 8] = bus_rdata[8*(m_off + j) +: 8];
          m_rdata = r;
        end
      end else if (m_used + 1 >= TO - 1) begin
        m_busy = 0; m_finish = 1; m_err = 1; m_rdata = '0;
      end
      m_used++;
    end else if (MemRead || MemWrite) begin
      m_n    = nbytes(Size);
      m_off  = int'(Addr[1:0]);
      m_read = MemRead;
      if ((m_off % m_n) != 0) begin
        m_finish = 1; m_err = 1; m_rdata = '0;
      end else begin
        m_addr = Addr - 32'(m_off);
        for (int i = 0; i < 4; i++) begin
          m_be[i] = (i >= m_off) && (i < m_off + m_n);
          m_wdata[8*i +: 8] = StoreData[8*(i % m_n) +: 8];
        end
        m_we = MemWrite; m_busy = 1; m_granted = 0; m_used = 0;
        m_err = 0; m_rdata = '0;
      end
    end
  endtask

  task automatic compare();
    bit exp_stall;
    exp_stall = !m_finish && (m_busy || MemRead || MemWrite);
    m_stall = exp_stall;
    chk("stall", 32'(Stall), 32'(exp_stall));
    chk("bus_req", 32'(bus_req), 32'(m_busy && !m_granted));
    chk("bus_addr", bus_addr, m_addr);
    chk("bus_be", 32'(bus_be), 32'(m_be));
    chk("bus_wdata", bus_wdata, m_wdata);
    chk("bus_we", 32'(bus_we), 32'(m_we));
    chk("mem_err", 32'(MemErr), 32'(m_finish && m_err));
    if (m_finish && m_read) chk("read_data", ReadData, m_rdata);
    if (!reset) chk("read_data_rst", ReadData, 32'd0);
    s_stall = Stall; s_req = bus_req; s_err = MemErr; s_rd = ReadData;
    s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata; s_we = bus_we;
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic step();
    if (!reset) model_reset();
    #1;
    compare();
    @(posedge clk);
    if (reset) model_update(); else model_reset();
    @(negedge clk);
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdw,
                        input int gnt_at, input int rv_at,
                        output int stalls, output int reqs, output logic [31:0] rd_o,
                        output logic err_o, output logic [31:0] f_addr,
                        output logic [31:0] f_wdata, output logic [3:0] f_be, output logic f_we);
    MemRead = rd; MemWrite = wr; Size = sz; Addr = a; StoreData = sd;
    stalls = 0; reqs = 0; rd_o = '0; err_o = 1'b0;
    f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_gnt = (i >= gnt_at); bus_rvalid = (i >= rv_at); bus_rdata = rdw;
      step();
      if (s_req) begin
        reqs++; f_addr = s_addr; f_wdata = s_wdata; f_be = s_be; f_we = s_we;
      end
      if (s_stall) stalls++;
      else begin
        rd_o = s_rd; err_o = s_err;
        break;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, rq;
    logic [31:0] rd, fa, fw;
    logic er, fwe;
    logic [3:0] fb;
    logic [1:0] am;

    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'd0; Addr = '0; StoreData = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    model_reset();
    @(negedge clk);
    step(); step();
    chk("rst_bus_req", 32'(s_req), 32'd0);
    chk("rst_bus_addr", s_addr, 32'd0);
    chk("rst_bus_be", 32'(s_be), 32'd0);
    chk("rst_bus_wdata", s_wdata, 32'd0);
    chk("rst_bus_we", 32'(s_we), 32'd0);
    chk("rst_read_data", s_rd, 32'd0);
    chk("rst_mem_err", 32'(s_err), 32'd0);
    chk("rst_stall_idle", 32'(s_stall), 32'd0);
    MemRead = 1'b1; Size = 2'd2; Addr = 32'h40;
    step();
    chk("rst_stall_req", 32'(s_stall), 32'd1);
    MemRead = 1'b0;
    reset = 1'b1;
    step();

    run_op(1, 0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2, st, rq, rd, er, fa, fw, fb, fwe);
    chk("lw_stalls", 32'(st), 32'd3);
    chk("lw_reqs", 32'(rq), 32'd1);
    chk("lw_addr", fa, 32'h100);
    chk("lw_be", 32'(fb), 32'hF);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);

    run_op(0, 1, 2'd0, 32'h203, 32'h5A, 32'h0, 1, 2, st, rq, rd, er, fa, fw, fb, fwe);
    chk("sb_addr", fa, 32'h200);
    chk("sb_be", 32'(fb), 32'h8);
    chk("sb_wdata", fw, 32'h5A5A5A5A);
    chk("sb_we", 32'(fwe), 32'd1);
    chk("sb_stalls", 32'(st), 32'd3);

    run_op(1, 0, 2'd1, 32'h102, 32'h0, 32'h80017FFF, 1, 0, st, rq, rd, er, fa, fw, fb, fwe);
    chk("lh_data", rd, 32'h00008001);
    chk("lh_be", 32'(fb), 32'hC);
    chk("lh_stalls", 32'(st), 32'd3);

    run_op(1, 0, 2'd2, 32'h101, 32'h0, 32'h0, 1, 2, st, rq, rd, er, fa, fw, fb, fwe);
    chk("mis_stalls", 32'(st), 32'd1);
    chk("mis_reqs", 32'(rq), 32'd0);
    chk("mis_err", 32'(er), 32'd1);

    run_op(1, 0, 2'd2, 32'h400, 32'h0, 32'h12345678, 99, 99, st, rq, rd, er, fa, fw, fb, fwe);
    chk("to_reqs", 32'(rq), 32'd3);
    chk("to_stalls", 32'(st), 32'd4);
    chk("to_err", 32'(er), 32'd1);
    chk("to_data", rd, 32'd0);

    MemRead = 1'b1; Size = 2'd2; Addr = 32'h300; bus_gnt = 1'b1; bus_rdata = 32'h11111111;
    step();
    step();
    bus_gnt = 1'b0;
    step();
    chk("wait_addr", s_addr, 32'h300);
    reset = 1'b0;
    #1;
    chk("arst_bus_req", 32'(bus_req), 32'd0);
    chk("arst_read_data", ReadData, 32'd0);
    chk("arst_bus_addr", bus_addr, 32'd0);
    chk("arst_stall", 32'(Stall), 32'd1);
    step();
    reset = 1'b1; MemRead = 1'b0; bus_rdata = '0;
    step();

    run_op(1, 0, 2'd2, 32'h500, 32'h0, 32'hCAFEF00D, 1, 2, st, rq, rd, er, fa, fw, fb, fwe);
    chk("fresh_data", rd, 32'hCAFEF00D);
    chk("fresh_stalls", 32'(st), 32'd3);
    run_op(1, 0, 2'd0, 32'h501, 32'h0, 32'h0000AB00, 1, 2, st, rq, rd, er, fa, fw, fb, fwe);
    chk("b2b_data", rd, 32'h000000AB);
    chk("b2b_stalls", 32'(st), 32'd3);
    chk("b2b_err", 32'(er), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      if (!m_stall) begin
        case ($urandom_range(0, 4))
          0:       begin MemRead = 1'b0; MemWrite = 1'b0; end
          1, 2:    begin MemRead = 1'b1; MemWrite = 1'b0; end
          default: begin MemRead = 1'b0; MemWrite = 1'b1; end
        endcase
        Size = 2'($urandom_range(0, 3));
        Addr = $urandom;
        StoreData = $urandom;
        am = (Size == 2'd0) ? 2'b00 : (Size == 2'd1) ? 2'b01 : 2'b11;
        if ($urandom_range(0, 3) != 0) Addr[1:0] = Addr[1:0] & ~am;
      end
      reset      = ($urandom_range(0, 499) != 0);
      bus_gnt    = ($urandom_range(0, 99) < 50);
      bus_rvalid = ($urandom_range(0, 99) < 50);
      bus_rdata  = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_bus_bridge.md
# lsu_bus_bridge

Load/store bus bridge sitting directly downstream of the single-cycle core datapath. Takes the datapath's memory address (ALU result), store data and access size, drives a request/response memory bus with byte enables and lane alignment, and returns right-aligned, unextended load data for the datapath's data extender. While a bus transaction is in flight it holds the core with a combinational `Stall`. It also flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles without grant/response before the access is aborted with error; legal range 2..255.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  current instruction is a load.
- `MemWrite`  in  1  current instruction is a store; `MemRead` and `MemWrite` are never both 1.
- `Size`  in  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
- `Addr`  in  32  byte address (datapath ALU result).
- `StoreData`  in  32  store value, right-aligned in bits [7:0]/[15:0]/[31:0].
- `ReadData`  out  32  load data shifted to bit 0, upper bits zero; valid in the DONE cycle.
- `Stall`  out  1  core must hold PC and suppress register write.
- `MemErr`  out  1  one-cycle pulse in DONE when the access was misaligned or timed out.
- `bus_req`  out  1  request valid.
- `bus_we`  out  1  1 write, 0 read.
- `bus_addr`  out  32  word address, with {Addr[31:2],2'b00}.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  store data replicated to the addressed lane.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  response (read data or write ack).
- `bus_rdata`  in  32  read word.

## Operation
- The FSM has four states.
  - IDLE: if `MemRead|MemWrite`, decide alignment. Aligned accesses latch addr, be, wdata, we and the offset, then go to REQ. Misaligned accesses go to DONE with the error flag set. In both cases `Stall`=1 this cycle.
  - REQ: `bus_req`=1 with the latched fields held stable. On `bus_gnt`, go to WAIT.
  - WAIT: on `bus_rvalid`, capture `bus_rdata` (reads only) and go to DONE. `bus_rvalid` is ignored in REQ and in the grant cycle.
  - DONE: `Stall`=0. `ReadData` and `MemErr` are valid. Next state is always IDLE, so back-to-back memory instructions restart cleanly.
- Misalignment is half with Addr[0]=1, or word with Addr[1:0]≠0.
- Byte enables:
  - byte: `be` = 1<<Addr[1:0].
  - half: `be` = 4'b0011<<Addr[1:0].
  - word: `be` = 4'b1111.
- Write data replication:
  - byte: {4{StoreData[7:0]}}.
  - half: {2{StoreData[15:0]}}.
  - word: `StoreData`.
- Load alignment: `ReadData` = `bus_rdata` >> (8*offset), masked to size. Upper bits are 0; sign extension is done downstream.
- Timeout:
  - An 8-bit counter clears on leaving IDLE and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without the exiting event, go to DONE with the error flag set and `ReadData`=0.
  - `bus_req` drops as REQ is left.
- An error is reported for exactly one cycle (DONE). The instruction then completes; trap handling is outside this block.
- `Stall` = (state≠DONE) & (state≠IDLE | MemRead | MemWrite).

## Timing
- Reset (async, `reset`=0): state IDLE, counter 0. Outputs:
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0.
  - `ReadData`=0, `MemErr`=0.
  - `Stall` follows its combinational equation, so it is 1 if a request is present.
- Reset asserted mid-transaction deasserts `bus_req` immediately and abandons the access. The bus must tolerate a dropped request.
- Best-case latency (grant in the first REQ cycle, `bus_rvalid` the following cycle): IDLE, REQ, WAIT, DONE. That is 3 stall cycles, with the instruction retiring in the 4th cycle.
- A misaligned access stalls 1 cycle (IDLE→DONE) and issues no bus request.
- No memory access: `Stall`=0 and the bridge stays in IDLE.
- Bus fields are registered and change only on leaving IDLE.

## Test plan
- Word load at 0x100, `bus_gnt` in the first REQ cycle, `bus_rvalid` the next cycle with 0xDEADBEEF -> `bus_be`=4'hF and `bus_addr`=0x100. `Stall` is high for 3 cycles, then `ReadData`=0xDEADBEEF with `Stall`=0 and `MemErr`=0.
- Byte store 0x5A at 0x203 -> `bus_addr`=0x200, `bus_be`=4'b1000, `bus_wdata`=0x5A5A5A5A, `bus_we`=1. The instruction completes after the ack.
- Half load at 0x102 returning `bus_rdata`=0x8001_7FFF -> `ReadData`=0x0000_8001.
- Word load at 0x101 -> no `bus_req`. `Stall` is high for 1 cycle, then `MemErr`=1 for one cycle.
- With `bus_gnt` held low and TIMEOUT=4 -> `bus_req` is high for 3 cycles, then DONE with `MemErr`=1 and `ReadData`=0.
- Assert `reset` low during WAIT -> `bus_req`=0 and `ReadData`=0 immediately. After release, a fresh load completes normally; also run two consecutive loads to check the DONE→IDLE restart.
